// File: rtl/harvos_pkg.sv
// Shared trap-sequencing types and constants.
package harvos_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } trap_state_e;

    localparam logic [1:0] STVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] STVEC_MODE_VECTORED = 2'b01;

    // scause interrupt flag sits in the MSB of the CSR.
    function automatic int unsigned scause_int_bit(input int unsigned xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Precise trap sequencer: arbitrate, drain, commit CSRs, redirect fetch; also handles sret.
// Optional trap counter output enabled by defining HARVOS_TRAP_STATS_EN.
module trap_ctrl
    import harvos_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_IRQ        = 4,
    parameter int unsigned CAUSE_W        = 5,
    parameter int unsigned IRQ_CAUSE_BASE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_req,
    output logic               exc_ack,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               sret_req,
    input  logic [XLEN-1:0]    stvec_q,
    output logic               drain_req,
    input  logic               pipe_drained,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    sepc_q,
    output logic [XLEN-1:0]    scause_q,
    output logic [XLEN-1:0]    stval_q,
    output logic               sie_q,
    output logic               spie_q,
    output logic               busy
`ifdef HARVOS_TRAP_STATS_EN
    ,
    output logic [31:0]        trap_count
`endif
);

    localparam int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned INT_BIT = scause_int_bit(XLEN);

    trap_state_e state_q, state_d;

    logic [XLEN-1:0]    pc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    tval_q;
    logic               int_q;
    logic               sret_q;

    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic [CAUSE_W-1:0] irq_cause;
    logic               irq_take;
    logic               take_exc;
    logic               take_irq;
    logic               take_sret;
    logic               commit_entry;
    logic [XLEN-1:0]    stvec_base;
    logic [XLEN-1:0]    sepc_base;
    logic [XLEN-1:0]    scause_d;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_irq_prio_enc (
        .req   (irq_pending & irq_enable),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign irq_cause    = CAUSE_W'(IRQ_CAUSE_BASE) + CAUSE_W'(irq_idx);
    assign irq_take     = sie_q & irq_valid;
    assign take_exc     = (state_q == IDLE) & exc_req;
    assign take_irq     = (state_q == IDLE) & ~exc_req & irq_take;
    // An sret colliding with a trap is dropped; the trap wins.
    assign take_sret    = (state_q == IDLE) & sret_req & ~exc_req & ~irq_take;
    assign commit_entry = (state_q == DRAIN) & pipe_drained;
    assign stvec_base   = {stvec_q[XLEN-1:2], 2'b00};
    assign sepc_base    = {sepc_q[XLEN-1:2], 2'b00};
    assign busy         = (state_q != IDLE);

    always_comb begin
        scause_d                = XLEN'(cause_q);
        scause_d[INT_BIT]       = int_q;
    end

    always_comb begin
        state_d        = state_q;
        exc_ack        = 1'b0;
        drain_req      = 1'b0;
        redirect_valid = sret_q;
        redirect_pc    = sepc_base;
        unique case (state_q)
            IDLE: begin
                if (exc_req) begin
                    exc_ack = ~rst;
                    state_d = DRAIN;
                end else if (irq_take) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_req = 1'b1;
                if (pipe_drained) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                redirect_valid = 1'b1;
                // Only mode 01 vectors, and only for interrupts; 1x behaves as direct.
                if ((stvec_q[1:0] == STVEC_MODE_VECTORED) && int_q) begin
                    redirect_pc = stvec_base + (XLEN'(cause_q) << 2);
                end else begin
                    redirect_pc = stvec_base;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            int_q    <= 1'b0;
            sret_q   <= 1'b0;
            sepc_q   <= '0;
            scause_q <= '0;
            stval_q  <= '0;
            sie_q    <= 1'b0;
            spie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sret_q  <= take_sret;
            if (take_exc) begin
                pc_q    <= exc_pc;
                cause_q <= exc_cause;
                tval_q  <= exc_tval;
                int_q   <= 1'b0;
            end else if (take_irq) begin
                pc_q    <= exc_pc;
                cause_q <= irq_cause;
                tval_q  <= '0;
                int_q   <= 1'b1;
            end
            if (commit_entry) begin
                sepc_q   <= {pc_q[XLEN-1:2], 2'b00};
                scause_q <= scause_d;
                stval_q  <= tval_q;
                spie_q   <= sie_q;
                sie_q    <= 1'b0;
            end else if (take_sret) begin
                sie_q  <= spie_q;
                spie_q <= 1'b1;
            end
        end
    end

`ifdef HARVOS_TRAP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count <= '0;
        end else if (commit_entry && (trap_count != 32'hFFFF_FFFF)) begin
            trap_count <= trap_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic        exc_ack;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic [3:0]  irq_pending;
    logic [3:0]  irq_enable;
    logic        sret_req;
    logic [31:0] stvec_q;
    logic        drain_req;
    logic        pipe_drained;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] sepc_q;
    logic [31:0] scause_q;
    logic [31:0] stval_q;
    logic        sie_q;
    logic        spie_q;
    logic        busy;
`ifdef HARVOS_TRAP_STATS_EN
    logic [31:0] trap_count;
`endif

    int passed = 0;
    int total  = 0;

    trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_ack        (exc_ack),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .exc_pc         (exc_pc),
        .irq_pending    (irq_pending),
        .irq_enable     (irq_enable),
        .sret_req       (sret_req),
        .stvec_q        (stvec_q),
        .drain_req      (drain_req),
        .pipe_drained   (pipe_drained),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sepc_q         (sepc_q),
        .scause_q       (scause_q),
        .stval_q        (stval_q),
        .sie_q          (sie_q),
        .spie_q         (spie_q),
        .busy           (busy)
`ifdef HARVOS_TRAP_STATS_EN
        ,
        .trap_count     (trap_count)
`endif
    );

    always #5 clk = ~clk;

    // The requester contract: sret never coincides with an exception.
    always @(posedge clk) begin
        assert (!(sret_req && exc_req))
        else $error("FAIL sret_overlap: sret_req and exc_req both high");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sret(input string tag, input logic [31:0] exp_pc);
        sret_req = 1'b1;
        @(negedge clk);
        chk({tag, "_pre_rv"}, 32'(redirect_valid), 32'd0);
        cyc();
        sret_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rv"}, 32'(redirect_valid), 32'd1);
        chk({tag, "_rpc"}, redirect_pc, exp_pc);
        cyc();
    endtask

    initial begin
        rst = 1'b1; exc_req = 1'b0; exc_cause = '0; exc_tval = '0; exc_pc = '0;
        irq_pending = '0; irq_enable = '0; sret_req = 1'b0; stvec_q = '0;
        pipe_drained = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sie", 32'(sie_q), 32'd0);
        chk("rst_spie", 32'(spie_q), 32'd0);
        chk("rst_sepc", sepc_q, 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_drain", 32'(drain_req), 32'd0);
        cyc();

        // Two srets raise sie: 0/0 -> sie=0,spie=1 -> sie=1,spie=1.
        do_sret("sret_a", 32'h0);
        @(negedge clk);
        chk("sret_a_sie", 32'(sie_q), 32'd0);
        chk("sret_a_spie", 32'(spie_q), 32'd1);
        cyc();
        do_sret("sret_b", 32'h0);
        @(negedge clk);
        chk("sret_b_sie", 32'(sie_q), 32'd1);
        cyc();

        // Exception, direct mode.
        stvec_q = 32'h8000_0100; exc_pc = 32'h1000_0042; exc_cause = 5'd2;
        exc_tval = 32'hDEAD_BEEF; exc_req = 1'b1;
        @(negedge clk);
        chk("exc_ack", 32'(exc_ack), 32'd1);
        chk("exc_idle_busy", 32'(busy), 32'd0);
        cyc();
        exc_req = 1'b0;
        @(negedge clk);
        chk("exc_ack_pulse", 32'(exc_ack), 32'd0);
        chk("exc_drain", 32'(drain_req), 32'd1);
        chk("exc_busy", 32'(busy), 32'd1);
        chk("exc_drain_rv", 32'(redirect_valid), 32'd0);
        cyc();
        pipe_drained = 1'b1;
        @(negedge clk);
        chk("exc_drain2", 32'(drain_req), 32'd1);
        cyc();
        pipe_drained = 1'b0;
        @(negedge clk);
        chk("exc_rv", 32'(redirect_valid), 32'd1);
        chk("exc_rpc", redirect_pc, 32'h8000_0100);
        chk("exc_commit_drain", 32'(drain_req), 32'd0);
        chk("exc_sepc", sepc_q, 32'h1000_0040);
        chk("exc_scause", scause_q, 32'h0000_0002);
        chk("exc_stval", stval_q, 32'hDEAD_BEEF);
        chk("exc_sie", 32'(sie_q), 32'd0);
        chk("exc_spie", 32'(spie_q), 32'd1);
        cyc();
        @(negedge clk);
        chk("exc_rv_pulse", 32'(redirect_valid), 32'd0);
        chk("exc_idle", 32'(busy), 32'd0);
        cyc();

        // Masking by sie=0.
        irq_pending = 4'b0001; irq_enable = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mask_sie", {30'd0, busy, drain_req}, 32'd0);
            cyc();
        end
        irq_pending = '0;

        // sret after trap returns to sepc and restores sie from spie.
        do_sret("sret_trap", 32'h1000_0040);
        @(negedge clk);
        chk("sret_trap_sie", 32'(sie_q), 32'd1);
        chk("sret_trap_spie", 32'(spie_q), 32'd1);
        cyc();

        // Masking by irq_enable=0.
        irq_pending = 4'hF; irq_enable = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mask_en", {30'd0, busy, drain_req}, 32'd0);
            cyc();
        end

        // Vectored interrupt: irq1 wins over irq2.
        stvec_q = 32'h8000_0001; exc_pc = 32'h2000_0010;
        irq_pending = 4'b0110; irq_enable = 4'hF;
        @(negedge clk);
        chk("irq_noack", 32'(exc_ack), 32'd0);
        cyc();
        pipe_drained = 1'b1;
        @(negedge clk);
        chk("irq_drain", 32'(drain_req), 32'd1);
        cyc();
        pipe_drained = 1'b0;
        @(negedge clk);
        chk("irq_rv", 32'(redirect_valid), 32'd1);
        chk("irq_rpc", redirect_pc, 32'h8000_0008);
        chk("irq_scause", scause_q, 32'h8000_0002);
        chk("irq_stval", stval_q, 32'h0);
        chk("irq_sepc", sepc_q, 32'h2000_0010);
        chk("irq_sie", 32'(sie_q), 32'd0);
        cyc();
        @(negedge clk);
        chk("irq_masked_after", 32'(busy), 32'd0);
        cyc();
        irq_pending = '0;

        // Simultaneous exception and interrupt; exception wins.
        do_sret("sret_re", 32'h2000_0010);
        exc_req = 1'b1; exc_cause = 5'd7; exc_pc = 32'h3000_0004; exc_tval = 32'h0000_1234;
        irq_pending = 4'b0001;
        @(negedge clk);
        chk("sim_ack", 32'(exc_ack), 32'd1);
        cyc();
        @(negedge clk);
        chk("sim_drain_noack", 32'(exc_ack), 32'd0);
        chk("sim_drain", 32'(drain_req), 32'd1);
        cyc();
        pipe_drained = 1'b1;
        @(negedge clk);
        chk("sim_drain_noack2", 32'(exc_ack), 32'd0);
        cyc();
        pipe_drained = 1'b0;
        @(negedge clk);
        chk("sim_rv", 32'(redirect_valid), 32'd1);
        chk("sim_rpc", redirect_pc, 32'h8000_0000);
        chk("sim_scause", scause_q, 32'h0000_0007);
        chk("sim_stval", stval_q, 32'h0000_1234);
        chk("sim_sepc", sepc_q, 32'h3000_0004);
        cyc();
        @(negedge clk);
        chk("b2b_ack", 32'(exc_ack), 32'd1);
        chk("b2b_idle", 32'(busy), 32'd0);
        cyc();
        exc_req = 1'b0; pipe_drained = 1'b1;
        @(negedge clk);
        chk("b2b_drain", 32'(drain_req), 32'd1);
        cyc();
        pipe_drained = 1'b0;
        @(negedge clk);
        chk("b2b_rv", 32'(redirect_valid), 32'd1);
        chk("b2b_spie", 32'(spie_q), 32'd0);
        cyc();
        irq_pending = '0;
        @(negedge clk);
        chk("b2b_idle_after", 32'(busy), 32'd0);
`ifdef HARVOS_TRAP_STATS_EN
        chk("count4", trap_count, 32'd4);
`endif
        cyc();

        // Reset mid-DRAIN aborts the trap.
        exc_req = 1'b1; exc_cause = 5'd3; exc_pc = 32'h4000_0000; exc_tval = 32'h5;
        @(negedge clk);
        chk("rd_ack", 32'(exc_ack), 32'd1);
        cyc();
        exc_req = 1'b0;
        @(negedge clk);
        chk("rd_drain", 32'(drain_req), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; pipe_drained = 1'b1;
        @(negedge clk);
        chk("rd_busy", 32'(busy), 32'd0);
        chk("rd_drain_off", 32'(drain_req), 32'd0);
        chk("rd_sepc", sepc_q, 32'd0);
        chk("rd_scause", scause_q, 32'd0);
        chk("rd_stval", stval_q, 32'd0);
        chk("rd_spie", 32'(spie_q), 32'd0);
`ifdef HARVOS_TRAP_STATS_EN
        chk("rd_count", trap_count, 32'd0);
`endif
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_no_redirect", 32'(redirect_valid), 32'd0);
            cyc();
        end
        pipe_drained = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised successor to the combinational trap vector/sepc helper.
- Sequences precise traps, covering both synchronous exceptions and NUM_IRQ level-sensitive interrupt lines.
- Sequence: arbitrate, request pipeline drain, wait for drain acknowledge, commit sepc/scause/stval/SIE/SPIE, issue one redirect pulse to fetch.
- Also handles sret, and supports direct and vectored stvec modes.
- Sits between the execute/commit stage, the CSR file and the fetch PC mux.

Parameters:
- XLEN, 32, datapath and CSR width.
- NUM_IRQ, 4, number of interrupt lines (1..16).
- CAUSE_W, 5, width of the exception cause code.
- IRQ_CAUSE_BASE, 1, cause code assigned to irq[0]; irq[i] gets IRQ_CAUSE_BASE+i.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- exc_req  in  1  exception request; held until exc_ack.
- exc_ack  out  1  one-cycle pulse when exception accepted.
- exc_cause  in  CAUSE_W  exception cause code.
- exc_tval  in  XLEN  faulting address/instruction.
- exc_pc  in  XLEN  PC of faulting/next-to-commit instruction.
- irq_pending  in  NUM_IRQ  level interrupt lines.
- irq_enable  in  NUM_IRQ  per-line enable (sie).
- sret_req  in  1  one-cycle sret commit strobe.
- stvec_q  in  XLEN  trap vector CSR; [1:0] is the mode field.
- drain_req  out  1  asks the pipeline to drain/flush.
- pipe_drained  in  1  pipeline empty; sampled only in DRAIN.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  XLEN  redirect target, 4-byte aligned.
- sepc_q  out  XLEN  saved PC.
- scause_q  out  XLEN  bit XLEN-1 = interrupt; low bits = cause code.
- stval_q  out  XLEN  trap value; 0 for interrupts.
- sie_q  out  1  global supervisor interrupt enable.
- spie_q  out  1  previous SIE.
- busy  out  1  high when FSM is not in IDLE.

Behaviour:
- Reset (rst high at an edge): state IDLE; all outputs and CSRs 0 (sie_q=0, spie_q=0, sepc/scause/stval=0). Reset mid-DRAIN/COMMIT aborts the trap; no redirect is issued.
- FSM states: IDLE, DRAIN, COMMIT.
- IDLE arbitration, priority exc_req > interrupt > sret_req:
  - Exception: exc_ack=1 combinationally this cycle. Latch pc/cause/tval and int=0. Next state DRAIN.
  - Interrupt: taken when sie_q=1 and (irq_pending & irq_enable) != 0. Lowest index wins; latch exc_pc, cause=IRQ_CAUSE_BASE+idx, tval=0, int=1. Next state DRAIN. No ack; lines are level.
  - sret alone: next cycle redirect_valid=1 and redirect_pc={sepc_q[XLEN-1:2],2'b00}; sie_q<=spie_q; spie_q<=1. State stays IDLE.
  - sret coinciding with exc/irq is dropped; the requester must not do this, and the bench asserts it.
- DRAIN: drain_req=1. Stays in DRAIN until pipe_drained=1 is sampled, then goes to COMMIT. No timeout. exc_req, irq and sret are ignored (exc_ack=0).
- COMMIT, exactly one cycle, then IDLE:
  - On entry edge: sepc_q<=latched pc with [1:0] forced to 0; scause_q<={int, zero-extended cause}; stval_q<=latched tval; spie_q<=sie_q; sie_q<=0.
  - redirect_valid=1 for this cycle; drain_req=0.
- redirect_pc in COMMIT, with base={stvec_q[XLEN-1:2],2'b00} sampled in COMMIT:
  - mode 00: base.
  - mode 01: base for exceptions; base+4*cause for interrupts.
  - modes 1x: treated as 00.
  - Arithmetic is modulo 2^XLEN; wrap-around is allowed.
- Minimum exception-to-redirect latency: 2 cycles after acceptance (accept, DRAIN with pipe_drained=1, COMMIT).
- Back-to-back: an exception may be accepted in the first IDLE cycle after COMMIT. Interrupts are masked there because sie_q=0.

Optional Feature:
- Macro: HARVOS_TRAP_STATS_EN.
- Defined: adds output trap_count[31:0], reset 0. It increments by 1 on each COMMIT and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (harvos_pkg): trap_state_e {IDLE,DRAIN,COMMIT}; STVEC_MODE_DIRECT=2'b00 and STVEC_MODE_VECTORED=2'b01 constants; the SCAUSE interrupt-bit position.
- Sub-module irq_prio_enc: parametrised by NUM_IRQ; outputs valid + lowest-set index of the masked pending vector.

Test Plan:
- Exception, direct mode: stvec=0x8000_0100, exc_pc=0x1000_0042, cause=2, tval=0xDEAD_BEEF, pipe_drained one cycle after drain_req. Expect exc_ack one pulse; redirect_pc=0x8000_0100; sepc=0x1000_0040; scause=2; stval=0xDEAD_BEEF; sie 1->0 and spie=1.
- Vectored interrupt: stvec=0x8000_0001, sie=1, irq_pending=4'b0110, enable=4'b1111. Expect irq1 taken; scause=0x8000_0002; redirect_pc=0x8000_0008; stval=0.
- Masking: sie=0, or irq_enable=0, with irq pending. Expect no drain_req and busy=0 over 20 cycles.
- Simultaneous events: exc_req with irq pending in the same cycle. Expect the exception wins (int=0), and exc_req asserted during DRAIN is not acked.
- sret after trap: sret_req pulse. Expect redirect_pc=sepc_q the next cycle; sie_q=prior spie; spie_q=1.
- Reset mid-DRAIN: hold pipe_drained=0 and assert rst. Expect no redirect_valid; all CSRs 0; FSM in IDLE; with HARVOS_TRAP_STATS_EN, trap_count stays 0.
